// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared constants and FSM state encoding for the register
//                file port controller.
//  Revision    : 1.0
// ============================================================================
package rf_pkg;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NREG = 8;

  // Register index reserved for the program counter.
  localparam logic [AW-1:0] PC_IDX = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FETCH = 2'd2,
    OPV   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rf_port_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_port_ctrl_if
//  Description : Bundle of decode, execute, writeback and register file
//                signals around the port controller. The master modport is
//                the controller's view; slave is its environment.
//  Revision    : 1.0
// ============================================================================
interface rf_port_ctrl_if;

  // Decode side
  logic                   dec_valid;
  logic                   dec_ready;
  logic [rf_pkg::AW-1:0]  dec_rs_a;
  logic [rf_pkg::AW-1:0]  dec_rs_b;
  logic [rf_pkg::AW-1:0]  dec_rd;
  logic                   dec_rd_we;

  // Execute side
  logic                   op_valid;
  logic                   op_ready;
  logic [rf_pkg::DW-1:0]  op_a;
  logic [rf_pkg::DW-1:0]  op_b;
  logic [rf_pkg::AW-1:0]  op_rd;

  // Writeback requests
  logic                   wb_valid;
  logic [rf_pkg::AW-1:0]  wb_rd;
  logic [rf_pkg::DW-1:0]  wb_data;
  logic                   pc_valid;
  logic [rf_pkg::DW-1:0]  pc_data;

  // Register file port
  logic [rf_pkg::AW-1:0]  ReadA;
  logic [rf_pkg::AW-1:0]  ReadB;
  logic [rf_pkg::DW-1:0]  OutA;
  logic [rf_pkg::DW-1:0]  OutB;
  logic                   WE_R;
  logic [rf_pkg::AW-1:0]  WrReg_Rd;
  logic [rf_pkg::DW-1:0]  InData_R;
  logic                   WE_PC;
  logic [rf_pkg::DW-1:0]  InData_PC;

  modport master (
    input  dec_valid, dec_rs_a, dec_rs_b, dec_rd, dec_rd_we,
    output dec_ready,
    output op_valid, op_a, op_b, op_rd,
    input  op_ready,
    input  wb_valid, wb_rd, wb_data, pc_valid, pc_data,
    output ReadA, ReadB,
    input  OutA, OutB,
    output WE_R, WrReg_Rd, InData_R, WE_PC, InData_PC
  );

  modport slave (
    output dec_valid, dec_rs_a, dec_rs_b, dec_rd, dec_rd_we,
    input  dec_ready,
    input  op_valid, op_a, op_b, op_rd,
    output op_ready,
    output wb_valid, wb_rd, wb_data, pc_valid, pc_data,
    input  ReadA, ReadB,
    output OutA, OutB,
    input  WE_R, WrReg_Rd, InData_R, WE_PC, InData_PC
  );

endinterface
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : Pending-write bit per register. Set has priority over
//                clear on the same index. The hazard flag ignores a bit that
//                is being cleared in the current cycle, so a writeback that
//                lands this cycle releases a stalled read immediately.
//  Revision    : 1.0
// ============================================================================
module rf_scoreboard #(
  parameter int AW   = 3,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_idx_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_idx_i,
  input  logic [AW-1:0] chk_a_i,
  input  logic [AW-1:0] chk_b_i,
  output logic          hazard_o
);

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;
  logic            w_hit_a;
  logic            w_hit_b;

  // Next pending vector: set beats clear when both target the same bit.
  always_comb begin
    sb_d = sb_q;
    for (int i = 0; i < NREG; i++) begin
      if (set_en_i && (set_idx_i == AW'(i))) begin
        sb_d[i] = 1'b1;
      end else if (clr_en_i && (clr_idx_i == AW'(i))) begin
        sb_d[i] = 1'b0;
      end
    end
  end

  // Pending vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // A source is blocked only if pending and not being written right now.
  always_comb begin
    w_hit_a  = sb_q[chk_a_i] && !(clr_en_i && (clr_idx_i == chk_a_i));
    w_hit_b  = sb_q[chk_b_i] && !(clr_en_i && (clr_idx_i == chk_b_i));
    hazard_o = w_hit_a || w_hit_b;
  end

endmodule
`default_nettype wire

// File: rtl/rf_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rf_port_ctrl
//  Description : Initiator side of the register file port. Issues one
//                dual-operand read per instruction, stalls on RAW hazards
//                via a pending-write scoreboard, and registers ALU and PC
//                writebacks onto the register file write ports.
//  Revision    : 1.0
// ============================================================================
module rf_port_ctrl
  import rf_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rf_port_ctrl_if.master bus
);

  state_t          state_q, state_d;
  logic [AW-1:0]   rs_a_q, rs_a_d;
  logic [AW-1:0]   rs_b_q, rs_b_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic            rd_we_q, rd_we_d;
  logic [AW-1:0]   read_a_q, read_a_d;
  logic [AW-1:0]   read_b_q, read_b_d;
  logic [DW-1:0]   op_a_q, op_a_d;
  logic [DW-1:0]   op_b_q, op_b_d;
  logic [AW-1:0]   op_rd_q, op_rd_d;
  logic            op_valid_q, op_valid_d;

  logic            we_r_q;
  logic [AW-1:0]   wr_rd_q;
  logic [DW-1:0]   in_r_q;
  logic            we_pc_q;
  logic [DW-1:0]   in_pc_q;

  logic            w_hazard;
  logic            w_sb_set;

  assign w_sb_set = (state_q == OPV) && bus.op_ready && rd_we_q;

  rf_scoreboard #(
    .AW   (AW),
    .NREG (NREG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (w_sb_set),
    .set_idx_i (rd_q),
    .clr_en_i  (we_r_q),
    .clr_idx_i (wr_rd_q),
    .chk_a_i   (rs_a_q),
    .chk_b_i   (rs_b_q),
    .hazard_o  (w_hazard)
  );

  // Writeback registers: one cycle from request to write enable. Data and
  // index hold their last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r_q  <= 1'b0;
      wr_rd_q <= '0;
      in_r_q  <= '0;
      we_pc_q <= 1'b0;
      in_pc_q <= '0;
    end else begin
      we_r_q  <= bus.wb_valid;
      we_pc_q <= bus.pc_valid;
      if (bus.wb_valid) begin
        wr_rd_q <= bus.wb_rd;
        in_r_q  <= bus.wb_data;
      end
      if (bus.pc_valid) begin
        in_pc_q <= bus.pc_data;
      end
    end
  end

  // Issue FSM next state, operand capture and read address generation.
  always_comb begin
    state_d    = state_q;
    rs_a_d     = rs_a_q;
    rs_b_d     = rs_b_q;
    rd_d       = rd_q;
    rd_we_d    = rd_we_q;
    read_a_d   = '0;
    read_b_d   = '0;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_rd_d    = op_rd_q;
    op_valid_d = op_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.dec_valid) begin
          rs_a_d  = bus.dec_rs_a;
          rs_b_d  = bus.dec_rs_b;
          rd_d    = bus.dec_rd;
          rd_we_d = bus.dec_rd_we;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Read addresses are registered so they are stable through FETCH.
        if (!w_hazard) begin
          read_a_d = rs_a_q;
          read_b_d = rs_b_q;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        // A write landing this cycle is not yet visible on OutA/OutB.
        op_a_d     = (we_r_q && (wr_rd_q == rs_a_q)) ? in_r_q : bus.OutA;
        op_b_d     = (we_r_q && (wr_rd_q == rs_b_q)) ? in_r_q : bus.OutB;
        op_rd_d    = rd_q;
        op_valid_d = 1'b1;
        state_d    = OPV;
      end
      OPV: begin
        if (bus.op_ready) begin
          op_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue FSM and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rs_a_q     <= '0;
      rs_b_q     <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      read_a_q   <= '0;
      read_b_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_rd_q    <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_a_q     <= rs_a_d;
      rs_b_q     <= rs_b_d;
      rd_q       <= rd_d;
      rd_we_q    <= rd_we_d;
      read_a_q   <= read_a_d;
      read_b_q   <= read_b_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_rd_q    <= op_rd_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign bus.dec_ready = (state_q == IDLE);
  assign bus.op_valid  = op_valid_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_rd     = op_rd_q;
  assign bus.ReadA     = read_a_q;
  assign bus.ReadB     = read_b_q;
  assign bus.WE_R      = we_r_q;
  assign bus.WrReg_Rd  = wr_rd_q;
  assign bus.InData_R  = in_r_q;
  assign bus.WE_PC     = we_pc_q;
  assign bus.InData_PC = in_pc_q;

endmodule
`default_nettype wire
